// File: rtl/led_bank_arbiter_if.sv
// Bundle of the arbiter's requester-side and LED-side signals.
// The slave modport is the arbiter's view. The master modport is the view of
// the pattern generators and the consumer of the LED drive.
interface led_bank_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic                   en;
    logic [NUM_REQ-1:0]     req;
    logic [4*NUM_REQ-1:0]   pat;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic [3:0]             led;

    modport master (
        output en, req, pat,
        input  grant, done, busy, led
    );

    modport slave (
        input  en, req, pat,
        output grant, done, busy, led
    );
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin time-slot owner of the 4-LED bank.
// The FSM runs IDLE -> GRANT -> GAP -> IDLE. Each grant lasts at most
// SLOT_CYCLES cycles. Each grant is followed by GAP_CYCLES cycles with the LEDs off.
// Optional feature macro: LED_ARB_PREEMPT_EN makes requester 0 urgent. It wins
// in IDLE and aborts any other owner's slot. When the macro is undefined, the
// arbiter is plain round-robin.
module led_bank_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int SLOT_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int CNT_W       = 26
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    led_bank_arbiter_if.slave    io_bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t             r_state,  w_state_next;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_next;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_next;
    logic [IDX_W-1:0]   r_owner,  w_owner_next;
    logic [NUM_REQ-1:0] r_grant,  w_grant_next;
    logic [NUM_REQ-1:0] r_done,   w_done_next;
    logic               r_busy,   w_busy_next;
    logic [3:0]         r_led,    w_led_next;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W:0]     w_scan;
    logic               w_preempt;
    logic               w_owner_req;
    logic               w_slot_end;

    assign w_owner_req = io_bus.req[r_owner];
    assign w_slot_end  = (r_cnt == CNT_W'(SLOT_CYCLES - 1));

`ifdef LED_ARB_PREEMPT_EN
    assign w_preempt = io_bus.req[0] && (r_owner != '0);
`else
    assign w_preempt = 1'b0;
`endif

    // Round-robin pick: the first set request scanning from r_rr_ptr upward, with wraparound.
    // The loop runs backwards so that the earliest position in scan order wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_scan       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(NUM_REQ))
                w_scan = w_scan - (IDX_W+1)'(NUM_REQ);
            if (io_bus.req[w_scan[IDX_W-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_scan[IDX_W-1:0];
            end
        end
`ifdef LED_ARB_PREEMPT_EN
        if (io_bus.req[0]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = '0;
        end
`endif
    end

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_rr_ptr_next = r_rr_ptr;
        w_owner_next  = r_owner;
        w_grant_next  = r_grant;
        w_done_next   = '0;
        w_busy_next   = r_busy;
        w_led_next    = r_led;

        if (!io_bus.en) begin
            // Disable drops everything at once. No done pulse is sent, and the rotation point is kept.
            w_state_next = S_IDLE;
            w_grant_next = '0;
            w_led_next   = 4'b0000;
            w_busy_next  = 1'b0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_grant_next = '0;
                    w_led_next   = 4'b0000;
                    w_busy_next  = 1'b0;
                    w_cnt_next   = '0;
                    if (w_pick_valid) begin
                        w_state_next  = S_GRANT;
                        w_grant_next  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        w_owner_next  = w_pick_idx;
                        w_busy_next   = 1'b1;
                        w_led_next    = io_bus.pat[{w_pick_idx, 2'b00} +: 4];
                        w_rr_ptr_next = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!w_owner_req || w_preempt || w_slot_end) begin
                        // A release or a preemption takes precedence over slot expiry, so done pulses only on a true timeout.
                        w_state_next = S_GAP;
                        w_grant_next = '0;
                        w_led_next   = 4'b0000;
                        w_cnt_next   = '0;
                        if (w_owner_req && !w_preempt)
                            w_done_next = r_grant;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                        w_led_next = io_bus.pat[{r_owner, 2'b00} +: 4];
                    end
                end
                S_GAP: begin
                    w_grant_next = '0;
                    w_led_next   = 4'b0000;
                    w_busy_next  = 1'b1;
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        w_state_next = S_IDLE;
                        w_busy_next  = 1'b0;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_grant_next = '0;
                    w_led_next   = 4'b0000;
                    w_busy_next  = 1'b0;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // State and output registers. Reset is asynchronous, so the LEDs blank immediately.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_led    <= 4'b0000;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_owner  <= w_owner_next;
            r_grant  <= w_grant_next;
            r_done   <= w_done_next;
            r_busy   <= w_busy_next;
            r_led    <= w_led_next;
        end
    end

    assign io_bus.grant = r_grant;
    assign io_bus.done  = r_done;
    assign io_bus.busy  = r_busy;
    assign io_bus.led   = r_led;
endmodule
